mem_stage: RTL and testbench

Memory stage of the 16-bit five-stage pipeline, directly downstream of `execute`. It holds the EX/MEM pipeline register and drives the `data_exmem` forwarding value back to `execute`. A small FSM performs multi-cycle data-memory reads and writes against a request/done memory port, stalling the pipeline while busy. It also loads the MEM/WB pipeline register consumed by write-back.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_reg.sv | 29 ++
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: data/register widths, memory-stage FSM states and
// the EX/MEM and MEM/WB pipeline-register payloads.
package pipe_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic          valid;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic          regwrite;
        logic          halt;
        logic [RW-1:0] wreg;
        logic [DW-1:0] alu;
        logic [DW-1:0] wdata;
    } exmem_t;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          halt;
        logic          err;
        logic [RW-1:0] wreg;
        logic [DW-1:0] data;
    } memwb_t;

endpackage

// File: rtl/pipe_reg.sv
// Enable-controlled pipeline register with asynchronous clear.
module pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = en ? d : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, request/done data-memory FSM with timeout,
// and the MEM/WB register feeding write-back.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu,
    input  logic [DW-1:0] ex_wdata,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    input  logic          ex_memtoreg,
    input  logic          ex_regwrite,
    input  logic          ex_halt,
    input  logic [RW-1:0] ex_wreg,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic [DW-1:0] data_exmem,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          wb_valid,
    output logic          wb_regwrite,
    output logic          wb_halt,
    output logic          wb_err,
    output logic [RW-1:0] wb_reg,
    output logic [DW-1:0] wb_data
);

    exmem_t          ex_in;
    exmem_t          exmem_q;
    memwb_t          memwb_d;
    memwb_t          memwb_q;
    state_e          state_d;
    state_e          state_q;
    logic [TO_W-1:0] cnt_d;
    logic [TO_W-1:0] cnt_q;
    logic            mem_op;
    logic            misaligned;
    logic            rd_done;
    logic            err;

    assign ex_in = '{ex_valid, ex_memread, ex_memwrite, ex_memtoreg,
                     ex_regwrite, ex_halt, ex_wreg, ex_alu, ex_wdata};

    pipe_reg #(.W($bits(exmem_t))) u_exmem (
        .clk (clk),
        .rst (rst),
        .en  (~stall),
        .d   (ex_in),
        .q   (exmem_q)
    );

    // Address and data come straight from EX/MEM, which is frozen while stalled.
    assign mem_op     = exmem_q.valid & (exmem_q.memread | exmem_q.memwrite);
    assign misaligned = mem_op & exmem_q.alu[0];
    assign mem_addr   = exmem_q.alu;
    assign mem_wdata  = exmem_q.wdata;
    assign data_exmem = exmem_q.alu;

    // Next state, stall and request decode; mem_done is only honoured in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        mem_req = 1'b0;
        mem_wr  = 1'b0;
        rd_done = 1'b0;
        err     = misaligned;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !misaligned) begin
                    mem_req = 1'b1;
                    mem_wr  = exmem_q.memwrite;
                    stall   = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    rd_done = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_W'(TIMEOUT)) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write-back payload; a bubble clears every field.
    always_comb begin
        memwb_d = '0;
        if (exmem_q.valid) begin
            memwb_d.valid    = 1'b1;
            memwb_d.regwrite = exmem_q.regwrite & ~err;
            memwb_d.halt     = exmem_q.halt;
            memwb_d.err      = err;
            memwb_d.wreg     = exmem_q.wreg;
            memwb_d.data     = (rd_done && exmem_q.memread && !exmem_q.memwrite
                                && exmem_q.memtoreg) ? mem_rdata : exmem_q.alu;
        end
    end

    pipe_reg #(.W($bits(memwb_t))) u_memwb (
        .clk (clk),
        .rst (rst),
        .en  (~stall),
        .d   (memwb_d),
        .q   (memwb_q)
    );

    assign wb_valid    = memwb_q.valid;
    assign wb_regwrite = memwb_q.regwrite;
    assign wb_halt     = memwb_q.halt;
    assign wb_err      = memwb_q.err;
    assign wb_reg      = memwb_q.wreg;
    assign wb_data     = memwb_q.data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan cases plus random
// instructions checked against a per-instruction transaction model.
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu;
    logic [15:0] ex_wdata;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        ex_regwrite;
    logic        ex_halt;
    logic [2:0]  ex_wreg;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic [15:0] data_exmem;
    logic        stall;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        wb_valid;
    logic        wb_regwrite;
    logic        wb_halt;
    logic        wb_err;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_alu      (ex_alu),
        .ex_wdata    (ex_wdata),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_memtoreg (ex_memtoreg),
        .ex_regwrite (ex_regwrite),
        .ex_halt     (ex_halt),
        .ex_wreg     (ex_wreg),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .data_exmem  (data_exmem),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .wb_valid    (wb_valid),
        .wb_regwrite (wb_regwrite),
        .wb_halt     (wb_halt),
        .wb_err      (wb_err),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bubble();
        ex_valid    = 1'b0;
        ex_alu      = '0;
        ex_wdata    = '0;
        ex_memread  = 1'b0;
        ex_memwrite = 1'b0;
        ex_memtoreg = 1'b0;
        ex_regwrite = 1'b0;
        ex_halt     = 1'b0;
        ex_wreg     = '0;
    endtask

    task automatic chk_wb_clear(input string tag);
        chk({tag, "_wb_valid"},    16'(wb_valid),    16'd0);
        chk({tag, "_wb_regwrite"}, 16'(wb_regwrite), 16'd0);
        chk({tag, "_wb_halt"},     16'(wb_halt),     16'd0);
        chk({tag, "_wb_err"},      16'(wb_err),      16'd0);
        chk({tag, "_wb_reg"},      16'(wb_reg),      16'd0);
        chk({tag, "_wb_data"},     wb_data,          16'd0);
    endtask

    // One instruction through the stage; lat = cycles after the request
    // until mem_done (values past TIMEOUT+1 mean the memory never answers).
    task automatic run_instr(input string tag, input logic v, input logic [15:0] alu,
                             input logic [15:0] wd, input logic rd, input logic wr,
                             input logic m2r, input logic rw, input logic hl,
                             input logic [2:0] rg, input int lat, input logic [15:0] rdat);
        logic        memop;
        logic        mis;
        logic        done;
        logic        err;
        int          stalls;
        int          exp_stalls;
        logic [15:0] exp_data;
        ex_valid = v; ex_alu = alu; ex_wdata = wd; ex_memread = rd; ex_memwrite = wr;
        ex_memtoreg = m2r; ex_regwrite = rw; ex_halt = hl; ex_wreg = rg;
        tick();
        drive_bubble();
        chk({tag, "_data_exmem"}, data_exmem, alu);
        memop  = v & (rd | wr);
        mis    = memop & alu[0];
        done   = 1'b0;
        err    = mis;
        stalls = 0;
        if (memop && !mis) begin
            chk({tag, "_mem_req"},   16'(mem_req), 16'd1);
            chk({tag, "_mem_wr"},    16'(mem_wr),  16'(wr));
            chk({tag, "_mem_addr"},  mem_addr,     alu);
            chk({tag, "_mem_wdata"}, mem_wdata,    wd);
            if (stall) stalls++;
            for (int k = 1; k <= int'(TIMEOUT) + 1; k++) begin
                tick();
                chk({tag, "_req_once"},  16'(mem_req), 16'd0);
                chk({tag, "_addr_hold"}, mem_addr,     alu);
                if (k == lat) begin
                    mem_done  = 1'b1;
                    mem_rdata = rdat;
                    done      = 1'b1;
                    #1;
                end
                if (!stall) break;
                stalls++;
            end
            err        = !done;
            exp_stalls = done ? lat : int'(TIMEOUT) + 1;
            chk({tag, "_stall_cycles"}, 16'(stalls), 16'(exp_stalls));
            tick();
            mem_done = 1'b0;
        end else begin
            chk({tag, "_no_stall"}, 16'(stall),   16'd0);
            chk({tag, "_no_req"},   16'(mem_req), 16'd0);
            tick();
        end
        exp_data = (done && rd && !wr && m2r) ? rdat : alu;
        if (!v) begin
            chk_wb_clear(tag);
        end else begin
            chk({tag, "_wb_valid"},    16'(wb_valid),    16'd1);
            chk({tag, "_wb_regwrite"}, 16'(wb_regwrite), 16'(rw & ~err));
            chk({tag, "_wb_halt"},     16'(wb_halt),     16'(hl));
            chk({tag, "_wb_err"},      16'(wb_err),      16'(err));
            chk({tag, "_wb_reg"},      16'(wb_reg),      16'(rg));
            chk({tag, "_wb_data"},     wb_data,          exp_data);
        end
    endtask

    // A mem_done pulse while idle must change nothing.
    task automatic late_done(input string tag);
        mem_done  = 1'b1;
        mem_rdata = 16'hDEAD;
        #1;
        chk({tag, "_stall"},   16'(stall),   16'd0);
        chk({tag, "_mem_req"}, 16'(mem_req), 16'd0);
        tick();
        mem_done = 1'b0;
        chk({tag, "_wb_valid"}, 16'(wb_valid), 16'd0);
        chk({tag, "_wb_data"},  wb_data,       16'd0);
    endtask

    initial begin
        logic        r_v;
        logic        r_rd;
        logic        r_wr;
        logic [15:0] r_alu;
        rst       = 1'b1;
        mem_done  = 1'b0;
        mem_rdata = '0;
        drive_bubble();
        tick();
        tick();
        chk("rst_stall",      16'(stall),   16'd0);
        chk("rst_mem_req",    16'(mem_req), 16'd0);
        chk("rst_data_exmem", data_exmem,   16'd0);
        chk_wb_clear("rst");
        rst = 1'b0;
        tick();

        run_instr("alu",   1, 16'h1234, 16'h0000, 0, 0, 0, 1, 0, 3'd3, 0, 16'h0);
        run_instr("load",  1, 16'h0040, 16'h0000, 1, 0, 1, 1, 0, 3'd5, 3, 16'hBEEF);
        run_instr("store", 1, 16'h0010, 16'h00AA, 0, 1, 0, 0, 0, 3'd0, 1, 16'h0);
        run_instr("misal", 1, 16'h0041, 16'h0000, 1, 0, 1, 1, 0, 3'd2, 0, 16'h0);
        run_instr("tmo",   1, 16'h0080, 16'h0000, 1, 0, 1, 1, 0, 3'd4, 99, 16'h0);
        late_done("tmo_late");
        run_instr("edge",  1, 16'h00A0, 16'h0000, 1, 0, 1, 1, 1, 3'd6, 16, 16'hCAFE);
        run_instr("rdwr",  1, 16'h0022, 16'h5555, 1, 1, 1, 1, 0, 3'd1, 2, 16'h7777);
        run_instr("bubble", 0, 16'h4321, 16'h0000, 1, 0, 1, 1, 1, 3'd7, 2, 16'h0);

        // Reset two cycles after the request abandons the access.
        ex_valid = 1; ex_alu = 16'h0100; ex_memread = 1; ex_memtoreg = 1;
        ex_regwrite = 1; ex_wreg = 3'd5;
        tick();
        drive_bubble();
        chk("rstw_mem_req", 16'(mem_req), 16'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstw_stall",      16'(stall),   16'd0);
        chk("rstw_mem_req",    16'(mem_req), 16'd0);
        chk("rstw_data_exmem", data_exmem,   16'd0);
        chk_wb_clear("rstw");
        tick();
        rst = 1'b0;
        tick();
        late_done("rstw_late");

        for (int i = 0; i < 40; i++) begin
            r_v   = ($urandom_range(0, 7) != 0);
            r_rd  = 1'($urandom_range(0, 1));
            r_wr  = 1'($urandom_range(0, 1));
            r_alu = 16'($urandom);
            if ($urandom_range(0, 4) != 0) r_alu[0] = 1'b0;
            run_instr("rand", r_v, r_alu, 16'($urandom), r_rd, r_wr,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      int'($urandom_range(1, 18)), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
